// File: rtl/dma_mem_responder_if.sv
// rtl/dma_mem_responder_if.sv - memory_if: word-addressed request/ready bus between DMA master and memory
//
// Signals:
//   addr[31:0]  byte address from master (bits [1:0] ignored by slaves)
//   wdata[31:0] write data from master
//   write_en    write request qualifier
//   read_en     read request qualifier
//   valid       request present
//   rdata[31:0] read data from slave, meaningful only while ready=1
//   ready       one-cycle completion pulse from slave
interface memory_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write_en;
    logic        read_en;
    logic        valid;
    logic [31:0] rdata;
    logic        ready;

    modport slave (
        input  addr,
        input  wdata,
        input  write_en,
        input  read_en,
        input  valid,
        output rdata,
        output ready
    );

    modport master (
        output addr,
        output wdata,
        output write_en,
        output read_en,
        output valid,
        input  rdata,
        input  ready
    );
endinterface

// File: rtl/dma_mem_responder.sv
// rtl/dma_mem_responder.sv - memory_if slave with programmable latency, stall injection, backdoor and counters
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (storage array is not reset)
//   mem_if     memory_if.slave: addr/wdata/write_en/read_en/valid in, rdata/ready out
//   stall      freezes the BUSY latency counter while high
//   dbg_we     backdoor write strobe
//   dbg_addr   backdoor word index
//   dbg_wdata  backdoor write data
//   dbg_rdata  combinational read of mem[dbg_addr]
//   err        one-cycle pulse alongside ready for an errored transaction
//   rd_count   completed reads, wrapping
//   wr_count   completed writes, wrapping
module dma_mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    memory_if.slave                  mem_if,
    input  logic                     stall,
    input  logic                     dbg_we,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    input  logic [31:0]              dbg_wdata,
    output logic [31:0]              dbg_rdata,
    output logic                     err,
    output logic [15:0]              rd_count,
    output logic [15:0]              wr_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    // Word address only; the byte offset is never needed after capture.
    logic [29:0] cap_word;
    logic [31:0] cap_wdata;
    logic        cap_rd;
    logic        cap_wr;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic          in_range;
    logic          txn_err;
    logic          finish;
    logic          do_write;

    assign idx      = cap_word[AW-1:0];
    assign in_range = (cap_word[29:AW] == '0);
    // Both or neither enable set is malformed, same as out of range.
    assign txn_err  = !in_range || (cap_rd == cap_wr);
    assign finish   = (state == BUSY) && !stall && (cnt == 8'd1);
    assign do_write = finish && cap_wr && !txn_err;

    assign dbg_rdata = mem[dbg_addr];

    // Storage has no reset. The functional write comes last so it wins
    // over a backdoor write to the same word at the same edge.
    always_ff @(posedge clk) begin
        if (dbg_we) begin
            mem[dbg_addr] <= dbg_wdata;
        end
        if (do_write) begin
            mem[idx] <= cap_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            cap_word     <= 30'd0;
            cap_wdata    <= 32'd0;
            cap_rd       <= 1'b0;
            cap_wr       <= 1'b0;
            mem_if.ready <= 1'b0;
            mem_if.rdata <= 32'd0;
            err          <= 1'b0;
            rd_count     <= 16'd0;
            wr_count     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_if.valid) begin
                        cap_word  <= mem_if.addr[31:2];
                        cap_wdata <= mem_if.wdata;
                        cap_rd    <= mem_if.read_en;
                        cap_wr    <= mem_if.write_en;
                        cnt       <= 8'(LATENCY);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (!stall) begin
                        if (cnt > 8'd1) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            state        <= RESP;
                            mem_if.ready <= 1'b1;
                            err          <= txn_err;
                            if (txn_err) begin
                                mem_if.rdata <= ERR_RDATA;
                            end else if (cap_rd) begin
                                mem_if.rdata <= mem[idx];
                            end
                            // Errored reads/writes still count; both-enables counts as neither.
                            if (cap_rd && !cap_wr) begin
                                rd_count <= rd_count + 16'd1;
                            end
                            if (cap_wr && !cap_rd) begin
                                wr_count <= wr_count + 16'd1;
                            end
                        end
                    end
                end
                RESP: begin
                    mem_if.ready <= 1'b0;
                    err          <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_mem_responder.sv
// tb/tb_dma_mem_responder.sv - self-checking bench for dma_mem_responder
module tb_dma_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        dbg_we;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [31:0] dbg_rdata;
    logic        err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    memory_if mif ();

    dma_mem_responder #(
        .DEPTH     (1024),
        .LATENCY   (LAT),
        .ERR_RDATA (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_if    (mif),
        .stall     (stall),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .err       (err),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int exp_rd = 0;
    int exp_wr = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        int          stall_n;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          exp_cyc;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
        logic        exp_err;
        int          tag;
    } exp_t;

    exp_t sb[$];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Response monitor: every ready pulse must match the head of the scoreboard.
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mif.ready) begin
                check("ready_pulse_width", 32'(prev_ready), 32'd0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ready: got ready=1 at cycle %0d expected no response", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("t%0d_ready_cycle", e.tag), 32'(cyc), 32'(e.exp_cyc));
                    check($sformatf("t%0d_err", e.tag), 32'(err), 32'(e.exp_err));
                    if (e.chk_rdata) begin
                        check($sformatf("t%0d_rdata", e.tag), mif.rdata, e.exp_rdata);
                    end
                end
            end else if (err) begin
                n_vec++;
                n_err++;
                $display("FAIL err_without_ready: got err=1 at cycle %0d expected 0", cyc);
            end
        end
        prev_ready = mif.ready;
    end

    task automatic backdoor_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        dbg_we = 1'b1;
        dbg_addr = a;
        dbg_wdata = d;
        @(negedge clk);
        dbg_we = 1'b0;
    endtask

    task automatic check_mem(input string name, input logic [9:0] a, input logic [31:0] d);
        dbg_addr = a;
        #1;
        check(name, dbg_rdata, d);
    endtask

    task automatic model_count(input logic rd, input logic wr);
        if (rd && !wr) exp_rd++;
        if (wr && !rd) exp_wr++;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got %0d pending responses expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_ready(input string name);
        int t = 0;
        while (!mif.ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!mif.ready) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got ready=0 expected ready=1", name);
        end
    endtask

    // Issue one request, scramble the bus while BUSY, inject stall, wait for completion.
    task automatic issue(input vec_t v, input int tag);
        int c0;
        @(negedge clk);
        mif.addr     = v.addr;
        mif.wdata    = v.wdata;
        mif.read_en  = v.rd;
        mif.write_en = v.wr;
        mif.valid    = 1'b1;
        c0 = cyc;
        sb.push_back('{c0 + LAT + 1 + v.stall_n, v.exp_rdata, v.chk_rdata, v.exp_err, tag});
        model_count(v.rd, v.wr);
        @(negedge clk);
        mif.valid    = 1'b0;
        mif.addr     = ~v.addr;
        mif.wdata    = ~v.wdata;
        mif.read_en  = ~v.rd;
        mif.write_en = v.rd;
        stall = (v.stall_n > 0);
        repeat (v.stall_n) @(negedge clk);
        stall = 1'b0;
        wait_drain($sformatf("t%0d", tag));
    endtask

    vec_t vecs[12];
    logic [31:0] cont_addr[3];
    int c0;

    initial begin
        vecs[0]  = '{32'h0000_0014, 32'h0,          1'b1, 1'b0, 0, 32'hCAFE0005, 1'b1, 1'b0};
        vecs[1]  = '{32'h0000_0020, 32'h12345678,   1'b0, 1'b1, 0, 32'h0,        1'b0, 1'b0};
        vecs[2]  = '{32'h0000_0020, 32'h0,          1'b1, 1'b0, 0, 32'h12345678, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_0014, 32'h0,          1'b1, 1'b0, 4, 32'hCAFE0005, 1'b1, 1'b0};
        vecs[4]  = '{32'h0000_1000, 32'h0,          1'b1, 1'b0, 0, 32'hDEADBEEF, 1'b1, 1'b1};
        vecs[5]  = '{32'h0000_1000, 32'hFFFFFFFF,   1'b0, 1'b1, 0, 32'h0,        1'b0, 1'b1};
        vecs[6]  = '{32'h0000_0017, 32'h0,          1'b1, 1'b0, 0, 32'hCAFE0005, 1'b1, 1'b0};
        vecs[7]  = '{32'h0000_0014, 32'h0,          1'b1, 1'b1, 0, 32'h0,        1'b0, 1'b1};
        vecs[8]  = '{32'h0000_0014, 32'h77777777,   1'b0, 1'b0, 0, 32'h0,        1'b0, 1'b1};
        vecs[9]  = '{32'h0000_0FFC, 32'hA5A5A5A5,   1'b0, 1'b1, 0, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{32'h0000_0FFC, 32'h0,          1'b1, 1'b0, 1, 32'hA5A5A5A5, 1'b1, 1'b0};
        vecs[11] = '{32'hFFFF_FFFC, 32'h0,          1'b1, 1'b0, 0, 32'hDEADBEEF, 1'b1, 1'b1};

        rst_n = 1'b0;
        stall = 1'b0;
        dbg_we = 1'b0;
        dbg_addr = '0;
        dbg_wdata = '0;
        mif.addr = '0;
        mif.wdata = '0;
        mif.read_en = 1'b0;
        mif.write_en = 1'b0;
        mif.valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", 32'(mif.ready), 32'd0);
        check("reset_rdata", mif.rdata, 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_rd_count", 32'(rd_count), 32'd0);
        check("reset_wr_count", 32'(wr_count), 32'd0);

        backdoor_write(10'd5, 32'hCAFE0005);
        backdoor_write(10'd0, 32'h0BAD0000);
        backdoor_write(10'd16, 32'h16161616);
        check_mem("backdoor_mem5", 10'd5, 32'hCAFE0005);

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i], i);
        end
        check_mem("write_mem8", 10'd8, 32'h12345678);
        check_mem("oob_write_mem0", 10'd0, 32'h0BAD0000);
        check_mem("both_en_mem5", 10'd5, 32'hCAFE0005);
        check_mem("top_word_mem1023", 10'd1023, 32'hA5A5A5A5);
        check("table_rd_count", 32'(rd_count), 32'(exp_rd));
        check("table_wr_count", 32'(wr_count), 32'(exp_wr));

        // valid held high across three reads; addr moves on each ready.
        backdoor_write(10'd40, 32'h40404040);
        backdoor_write(10'd41, 32'h41414141);
        backdoor_write(10'd42, 32'h42424242);
        cont_addr[0] = 32'd160;
        cont_addr[1] = 32'd164;
        cont_addr[2] = 32'd168;
        @(negedge clk);
        mif.addr = cont_addr[0];
        mif.read_en = 1'b1;
        mif.write_en = 1'b0;
        mif.valid = 1'b1;
        c0 = cyc;
        sb.push_back('{c0 + LAT + 1,           32'h40404040, 1'b1, 1'b0, 100});
        sb.push_back('{c0 + 2 * LAT + 3,       32'h41414141, 1'b1, 1'b0, 101});
        sb.push_back('{c0 + 3 * LAT + 5,       32'h42424242, 1'b1, 1'b0, 102});
        for (int k = 0; k < 3; k++) model_count(1'b1, 1'b0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            wait_ready("cont");
            mif.addr = cont_addr[k];
        end
        @(negedge clk);
        wait_ready("cont_last");
        mif.valid = 1'b0;
        wait_drain("cont");
        check("cont_rd_count", 32'(rd_count), 32'(exp_rd));

        // Backdoor and functional write hit word 12 on the same edge.
        @(negedge clk);
        mif.addr = 32'h30;
        mif.wdata = 32'h11112222;
        mif.read_en = 1'b0;
        mif.write_en = 1'b1;
        mif.valid = 1'b1;
        c0 = cyc;
        sb.push_back('{c0 + LAT + 1, 32'h0, 1'b0, 1'b0, 200});
        model_count(1'b0, 1'b1);
        @(negedge clk);
        mif.valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        dbg_we = 1'b1;
        dbg_addr = 10'd12;
        dbg_wdata = 32'h99998888;
        @(negedge clk);
        dbg_we = 1'b0;
        wait_drain("collide");
        check_mem("collide_mem12", 10'd12, 32'h11112222);
        check("collide_wr_count", 32'(wr_count), 32'(exp_wr));

        // Reset while BUSY on a write to word 16.
        @(negedge clk);
        mif.addr = 32'h40;
        mif.wdata = 32'hBBBBBBBB;
        mif.read_en = 1'b0;
        mif.write_en = 1'b1;
        mif.valid = 1'b1;
        @(negedge clk);
        mif.valid = 1'b0;
        rst_n = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_ready", 32'(mif.ready), 32'd0);
        check("rst_rdata", mif.rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'(exp_rd));
        check("rst_wr_count", 32'(wr_count), 32'(exp_wr));
        check_mem("rst_mem16", 10'd16, 32'h16161616);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dma_mem_responder.md
Name: dma_mem_responder

Overview:
- Slave end of memory_if: the word-addressed memory the DMA controller's master port talks to.
- Accepts one read or write request at a time and holds ready low for a programmable latency plus bench-controlled stall cycles.
- Then pulses ready for exactly one cycle, with rdata valid in that same cycle.
- Includes a backdoor port for preload/checking and transaction counters; used as the system-level memory in DMA simulation and FPGA bring-up.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, ≥2
LATENCY, 2, cycles spent in BUSY before ready with no stall; legal range 1..255
ERR_RDATA, 32'hDEADBEEF, rdata returned for out-of-range or errored reads

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_if  modport  memory_if.slave  addr[31:0], wdata[31:0], write_en, read_en, valid in; rdata[31:0], ready out
stall  input  1  while high, the BUSY latency counter freezes (injects wait states)
dbg_we  input  1  backdoor write strobe
dbg_addr  input  log2(DEPTH)  backdoor word index
dbg_wdata  input  32  backdoor write data
dbg_rdata  output  32  combinational read of mem[dbg_addr]
err  output  1  one-cycle pulse, coincident with ready, on an errored transaction
rd_count  output  16  completed reads, wraps at 16'hFFFF→0
wr_count  output  16  completed writes, wraps

Behaviour:
- Reset (async, rst_n low): state=IDLE, mem_if.ready=0, mem_if.rdata=0, err=0, rd_count=0, wr_count=0, latency counter=0. The storage array is NOT reset.
- Word index = addr[log2(DEPTH)+1:2]. addr[1:0] are ignored.
- In range means addr[31:2] < DEPTH; otherwise out of range.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If valid=1 at the edge: capture addr, wdata, read_en, write_en; cnt←LATENCY; go to BUSY.
  - If valid=0: stay in IDLE.
  - valid with read_en=write_en=0 is still captured and completes as an errored no-op.
- BUSY:
  - stall=1: hold state and cnt.
  - stall=0 and cnt>1: cnt←cnt−1.
  - stall=0 and cnt==1: go to RESP and register ready←1.
  - Read: rdata←mem[idx], or ERR_RDATA if errored.
  - Write: mem[idx]←captured wdata unless errored.
  - Increment the matching counter; register err←1 if errored.
- RESP: ready=1 for exactly this one cycle. On the next edge: ready←0, err←0, go to IDLE. valid is ignored during RESP.
- Latency: first valid cycle c0 → ready high in cycle c0+LATENCY+1+(number of stall-high BUSY cycles).
- Back-to-back requests: a request presented in the cycle right after RESP is accepted. Minimum issue interval is LATENCY+2 cycles.
- After capture, the request is committed. Changes to valid, addr or wdata during BUSY are ignored, and the transaction completes with the captured values.
- Errored transaction (out of range, both enables set, or neither set):
  - No array write; read data is ERR_RDATA.
  - ready still pulses and err pulses with it.
  - Both enables set counts as neither a read nor a write; the counters are not incremented.
- rdata holds its last value outside RESP. Masters must sample rdata only when ready=1.
- Backdoor:
  - dbg_we writes at the clock edge in any state.
  - If it hits the same index as a functional write at the same edge, the functional write wins.
  - dbg_rdata is a combinational read of the array.
- Reset mid-transaction: the in-flight request is abandoned, ready stays 0 and no write occurs; array contents persist.

Test Plan:
- Backdoor-load mem[5]=32'hCAFE0005, LATENCY=2, issue a read at addr 0x14 with stall=0 → ready is a single pulse in c0+3, rdata=32'hCAFE0005, rd_count=1, err=0.
- Write addr 0x20, wdata 32'h12345678 → after the ready pulse, dbg_rdata at dbg_addr=8 is 32'h12345678 and wr_count=1. Then read back 0x20 → same data.
- Read with stall held high for 4 cycles during BUSY → ready arrives exactly 4 cycles later than the stall-free case and still pulses once.
- With DEPTH=1024, read at addr 0x1000 → rdata=32'hDEADBEEF and err pulses with ready. Write at 0x1000 → no word changes (spot-check mem[0]).
- Keep valid asserted continuously across 3 reads at different addresses (addr changed on each ready) → three separate ready pulses, each LATENCY+2 cycles apart, each returning correct data.
- Assert rst_n low while in BUSY for a write to 0x40 → ready never pulses, mem[16] is unchanged, and all outputs and counters read 0 after reset.
